// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer. This block requests branch targets from the
// PC_LUT branch-target lookup. It sits between the decode stage, which
// supplies branch_en and branch_tag, and instruction memory, which takes pc.
//
// In normal operation the PC advances by one each cycle. A taken branch
// registers its tag on lut_tag and spends one BRANCH cycle waiting for the
// combinational lut_target. The sequencer then loads pc from lut_target and
// returns to RUN. stall freezes the sequencer. halt_req parks it in DONE,
// where it stays until the next start.
//
// Ports
//   clk         in   1      rising-edge clock
//   reset       in   1      asynchronous, active-high reset
//   start       in   1      1-cycle pulse; (re)starts execution at START_ADDR
//   stall       in   1      hold pc and state this cycle
//   halt_req    in   1      stop execution and enter DONE
//   branch_en   in   1      taken branch this cycle; tag on branch_tag
//   branch_tag  in   TAG_W  branch tag to look up
//   lut_tag     out  TAG_W  registered tag presented to PC_LUT
//   lut_target  in   PC_W   PC_LUT combinational result for lut_tag
//   pc          out  PC_W   current fetch address (registered)
//   running     out  1      1 while in RUN or BRANCH (registered)
//   done        out  1      1 while in DONE (registered)
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int                 PC_W       = 12,
  parameter int                 TAG_W      = 8,
  parameter logic [PC_W-1:0]    START_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              branch_en,
  input  logic [TAG_W-1:0]  branch_tag,
  output logic [TAG_W-1:0]  lut_tag,
  input  logic [PC_W-1:0]   lut_target,
  output logic [PC_W-1:0]   pc,
  output logic              running,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_BRANCH = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t             state_q;
  logic [PC_W-1:0]    pc_q;
  logic [TAG_W-1:0]   lut_tag_q;
  logic               running_q;
  logic               done_q;

  // Sequential increment. The carry out of the top bit is dropped, so
  // 0xFFF + 1 wraps to 0x000 without raising any flag.
  logic [PC_W-1:0]    pc_inc_d;
  assign pc_inc_d = pc_q + PC_W'(1);

  // The FSM and all its outputs live in one clocked process. running and done
  // are updated together with every state change. As a result they always
  // match the state, and they leave the block glitch-free.
  // NOTE: every register below is assigned with <= so that all of them sample
  // the values from before the edge. With = they would see each other's new
  // values, and the behaviour would depend on statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= START_ADDR;
      lut_tag_q <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        // Waiting for the first start. Every other input is ignored here,
        // including branch_en.
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_RUN;
            pc_q      <= START_ADDR;
            running_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end

        // Normal fetch. Priority is halt_req > stall > branch_en > increment.
        // A branch seen during a stall is dropped, because decode presents
        // it again once the stall clears.
        ST_RUN: begin
          if (halt_req) begin
            state_q   <= ST_DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (stall) begin
            state_q   <= ST_RUN;
          end else if (branch_en) begin
            // pc holds for one bubble while PC_LUT resolves the new tag.
            state_q   <= ST_BRANCH;
            lut_tag_q <= branch_tag;
          end else begin
            pc_q      <= pc_inc_d;
          end
        end

        // lut_tag was registered on the previous edge, so lut_target is now
        // valid. lut_tag must stay unchanged here, including through a
        // stall, so that the target read at the end of this state belongs
        // to the accepted branch. A new branch_en is not accepted in this
        // state.
        ST_BRANCH: begin
          if (halt_req) begin
            // The pending branch is abandoned. pc keeps its pre-branch value.
            state_q   <= ST_DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (stall) begin
            state_q   <= ST_BRANCH;
          end else begin
            state_q   <= ST_RUN;
            pc_q      <= lut_target;
          end
        end

        // Parked. pc and lut_tag keep their last values. Only start leaves
        // this state. halt_req has no further effect.
        ST_DONE: begin
          if (start) begin
            state_q   <= ST_RUN;
            pc_q      <= START_ADDR;
            running_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          pc_q      <= START_ADDR;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign pc      = pc_q;
  assign lut_tag = lut_tag_q;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Self-checking bench for pc_sequencer. The PC_LUT is modelled as
// lut_target = {4'h0, lut_tag} << 2. Each table row holds one cycle of inputs
// and the outputs expected after the next rising edge. When a row is driven,
// its expectation is pushed to a scoreboard queue. The expectation is popped
// and compared just after the edge. Hand-written sequences cover PC wrap and
// asynchronous reset.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int PC_W  = 12;
  localparam int TAG_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start, stall, halt_req, branch_en;
  logic [TAG_W-1:0]  branch_tag;
  logic [TAG_W-1:0]  lut_tag;
  logic [PC_W-1:0]   lut_target;
  logic [PC_W-1:0]   pc;
  logic              running, done;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // PC_LUT model
  assign lut_target = {4'h0, lut_tag} << 2;

  pc_sequencer #(
    .PC_W       (PC_W),
    .TAG_W      (TAG_W),
    .START_ADDR ('0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stall      (stall),
    .halt_req   (halt_req),
    .branch_en  (branch_en),
    .branch_tag (branch_tag),
    .lut_tag    (lut_tag),
    .lut_target (lut_target),
    .pc         (pc),
    .running    (running),
    .done       (done)
  );

  typedef struct {
    string            name;
    logic             start;
    logic             stall;
    logic             halt;
    logic             ben;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  e_pc;
    logic [TAG_W-1:0] e_tag;
    logic             e_run;
    logic             e_done;
  } vec_t;

  typedef struct {
    string            name;
    logic [PC_W-1:0]  pc;
    logic [TAG_W-1:0] tag;
    logic             run;
    logic             done;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string name, input logic [PC_W-1:0] e_pc,
                               input logic [TAG_W-1:0] e_tag, input logic e_run,
                               input logic e_done);
    check({name, ".pc"},      32'(pc),      32'(e_pc));
    check({name, ".lut_tag"}, 32'(lut_tag), 32'(e_tag));
    check({name, ".running"}, 32'(running), 32'(e_run));
    check({name, ".done"},    32'(done),    32'(e_done));
  endtask

  task automatic add(input string name, input logic st, input logic sl,
                     input logic hl, input logic be, input logic [TAG_W-1:0] tg,
                     input logic [PC_W-1:0] epc, input logic [TAG_W-1:0] etg,
                     input logic erun, input logic edone);
    vecs.push_back('{name, st, sl, hl, be, tg, epc, etg, erun, edone});
  endtask

  // Called at a falling edge. Drives one cycle of inputs, then pops and
  // compares the expectation just after the rising edge.
  task automatic drive_cycle(input vec_t v);
    exp_t e;
    start      = v.start;
    stall      = v.stall;
    halt_req   = v.halt;
    branch_en  = v.ben;
    branch_tag = v.tag;
    sb.push_back('{v.name, v.e_pc, v.e_tag, v.e_run, v.e_done});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({v.name, ".scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_outputs(e.name, e.pc, e.tag, e.run, e.done);
    end
    @(negedge clk);
  endtask

  task automatic free_run(input int n);
    start = 1'b0; stall = 1'b0; halt_req = 1'b0; branch_en = 1'b0; branch_tag = '0;
    repeat (n) @(negedge clk);
  endtask

  // Guards against a bench or DUT hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    reset = 1'b1; start = 1'b0; stall = 1'b0; halt_req = 1'b0;
    branch_en = 1'b0; branch_tag = '0;

    //   name          st sl hl be tag     pc      tag    run done
    // 1: start, then free-running increment
    add("start",       1, 0, 0, 0, 8'h00, 12'h000, 8'h00, 1, 0);
    add("inc1",        0, 0, 0, 0, 8'h00, 12'h001, 8'h00, 1, 0);
    add("inc2",        0, 0, 0, 0, 8'h00, 12'h002, 8'h00, 1, 0);
    add("inc3",        0, 0, 0, 0, 8'h00, 12'h003, 8'h00, 1, 0);
    add("inc4",        0, 0, 0, 0, 8'h00, 12'h004, 8'h00, 1, 0);
    add("inc5",        0, 0, 0, 0, 8'h00, 12'h005, 8'h00, 1, 0);
    // 2: branch tag 0x01 -> 0x004; branch_en in BRANCH ignored
    add("br_accept",   0, 0, 0, 1, 8'h01, 12'h005, 8'h01, 1, 0);
    add("br_load",     0, 0, 0, 1, 8'h22, 12'h004, 8'h01, 1, 0);
    add("br_after",    0, 0, 0, 0, 8'h00, 12'h005, 8'h01, 1, 0);
    // 3: reach 0x010, stall 3 cycles (branch under stall dropped)
    add("br_to_10",    0, 0, 0, 1, 8'h04, 12'h005, 8'h04, 1, 0);
    add("at_10",       0, 0, 0, 0, 8'h00, 12'h010, 8'h04, 1, 0);
    add("stall1",      0, 1, 0, 0, 8'h00, 12'h010, 8'h04, 1, 0);
    add("stall2_br",   0, 1, 0, 1, 8'h33, 12'h010, 8'h04, 1, 0);
    add("stall3",      0, 1, 0, 0, 8'h00, 12'h010, 8'h04, 1, 0);
    add("unstall",     0, 0, 0, 0, 8'h00, 12'h011, 8'h04, 1, 0);
    // 3b: stall during BRANCH
    add("br_to_20",    0, 0, 0, 1, 8'h08, 12'h011, 8'h08, 1, 0);
    add("bstall1",     0, 1, 0, 1, 8'h09, 12'h011, 8'h08, 1, 0);
    add("bstall2",     0, 1, 0, 0, 8'h00, 12'h011, 8'h08, 1, 0);
    add("bload_20",    0, 0, 0, 0, 8'h00, 12'h020, 8'h08, 1, 0);
    add("inc_21",      0, 0, 0, 0, 8'h00, 12'h021, 8'h08, 1, 0);
    // 5: halt beats branch; DONE holds; start restarts
    add("halt_br",     0, 0, 1, 1, 8'h55, 12'h021, 8'h08, 0, 1);
    add("done_hold",   0, 0, 1, 0, 8'h00, 12'h021, 8'h08, 0, 1);
    add("restart",     1, 0, 0, 0, 8'h00, 12'h000, 8'h08, 1, 0);
    add("re_inc1",     0, 0, 0, 0, 8'h00, 12'h001, 8'h08, 1, 0);
    add("start_ign",   1, 0, 0, 0, 8'h00, 12'h002, 8'h08, 1, 0);
    // halt during BRANCH drops the branch
    add("br_to_40",    0, 0, 0, 1, 8'h10, 12'h002, 8'h10, 1, 0);
    add("halt_in_br",  0, 0, 1, 0, 8'h00, 12'h002, 8'h10, 0, 1);
    add("done_idle",   0, 0, 0, 0, 8'h00, 12'h002, 8'h10, 0, 1);
    add("restart2",    1, 0, 0, 0, 8'h00, 12'h000, 8'h10, 1, 0);

    repeat (3) @(negedge clk);
    check_outputs("reset_state", 12'h000, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check_outputs("idle_hold", 12'h000, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive_cycle(v);
    end

    // 4: wrap from 0xFFF to 0x000 (pc is 0x000 here)
    free_run(4095);
    check_outputs("at_fff", 12'hFFF, 8'h10, 1'b1, 1'b0);
    drive_cycle('{"wrap", 0, 0, 0, 0, 8'h00, 12'h000, 8'h10, 1, 0});

    // 6: async reset while in BRANCH, with start held high
    drive_cycle('{"br_pre_rst", 0, 0, 0, 1, 8'h07, 12'h000, 8'h07, 1, 0});
    reset = 1'b1;
    start = 1'b1;
    branch_en = 1'b0;
    #1;
    check_outputs("async_rst", 12'h000, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_outputs("rst_start_ign", 12'h000, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    drive_cycle('{"idle_br_ign", 0, 0, 0, 1, 8'h44, 12'h000, 8'h00, 0, 0});
    drive_cycle('{"post_rst_go", 1, 0, 0, 0, 8'h00, 12'h000, 8'h00, 1, 0});
    drive_cycle('{"post_rst_inc", 0, 0, 0, 0, 8'h00, 12'h001, 8'h00, 1, 0});

    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
